imem_fetch: RTL and testbench

IMEM_FETCH -- requirements
Module: imem_fetch

---
 rtl/imem_fetch_pkg.sv | 27 ++
 rtl/fetch_fifo.sv | 51 +++++
 rtl/imem_fetch.sv | 85 ++++++++
 tb/tb_imem_fetch.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_fetch_pkg.sv
// Shared constants and types for the instruction fetch slice: opcode field
// values, special instruction words and the fetch engine state encoding.
package imem_fetch_pkg;

  localparam logic [5:0] OP_ALU    = 6'h00;
  localparam logic [5:0] OP_ALUI   = 6'h01;
  localparam logic [5:0] OP_LOAD   = 6'h02;
  localparam logic [5:0] OP_STORE  = 6'h03;
  localparam logic [5:0] OP_BRANCH = 6'h04;
  localparam logic [5:0] OP_JUMP   = 6'h05;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

  // Queue entry is {pc[15:0], instr[31:0]}.
  localparam int FIFO_W = 48;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[31:26];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular queue with synchronous flush. Reports its fill level and
// presents zero on rdata while empty so downstream never sees stale data.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 48
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A full queue only accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign rdata   = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !(rst || flush)) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/imem_fetch.sv
// Instruction fetch engine: walks the pc through instruction memory, queues
// {pc, word} pairs for decode, stops on erased memory and honours redirects.
module imem_fetch
  import imem_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [15:0] out_pc,
  output logic        halted
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [15:0]       pc;
  logic [15:0]       pc_next;
  logic              push;
  logic              pop;
  logic              has_room;
  logic              is_halt_word;
  logic [CW-1:0]     count;
  logic [FIFO_W-1:0] head;

  assign imem_addr       = pc;
  assign out_valid       = (count != '0);
  assign {out_pc, out_instr} = head;
  assign halted          = (state == HALT);
  assign is_halt_word    = (imem_rdata == HALT_WORD);
  assign has_room        = (count < CW'(DEPTH)) || (out_valid && out_ready);
  assign pop             = out_valid && out_ready && !redirect_valid;

  // Redirect wins over everything; the flush also drops this cycle's push/pop.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    push       = 1'b0;
    if (redirect_valid) begin
      state_next = RUN;
      pc_next    = redirect_pc & ~16'h0003;
    end else if (state == RUN) begin
      if (is_halt_word) begin
        state_next = HALT;
      end else if (has_room) begin
        push    = 1'b1;
        pc_next = pc + 16'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FIFO_W)
  ) u_fetch_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata ({pc, imem_rdata}),
    .rdata (head),
    .count (count)
  );

endmodule

// File: tb/tb_imem_fetch.sv
// Bench for imem_fetch: directed scenarios plus a randomized phase, all
// checked against a queue-based reference model of the fetch rules.
module tb_imem_fetch;
  import imem_fetch_pkg::*;

  localparam int          DEPTH    = 2;
  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] WRAP_PC  = 16'hFFFC;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_ready;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [15:0] out_pc;
  logic        halted;

  logic [15:0] imem_addr2;
  logic [31:0] imem_rdata2;
  logic        out_valid2;
  logic [31:0] out_instr2;
  logic [15:0] out_pc2;
  logic        halted2;

  logic [31:0] wmem [16384];
  assign imem_rdata  = wmem[imem_addr[15:2]];
  assign imem_rdata2 = wmem[imem_addr2[15:2]];

  imem_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted)
  );

  imem_fetch #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH)) dut_wrap (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr2),
    .imem_rdata     (imem_rdata2),
    .redirect_valid (1'b0),
    .redirect_pc    (16'h0000),
    .out_valid      (out_valid2),
    .out_ready      (1'b1),
    .out_instr      (out_instr2),
    .out_pc         (out_pc2),
    .halted         (halted2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [15:0] m_pc;
  bit          m_halted;
  logic [47:0] m_q[$];

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit rv, input logic [15:0] rpc, input bit rdy);
    logic [31:0] w;
    if (r) begin
      m_pc = RESET_PC;
      m_q.delete();
      m_halted = 1'b0;
    end else if (rv) begin
      m_q.delete();
      m_pc = {rpc[15:2], 2'b00};
      m_halted = 1'b0;
    end else begin
      w = wmem[m_pc[15:2]];
      if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
      if (!m_halted) begin
        if (w == HALT_WORD) begin
          m_halted = 1'b1;
        end else if (m_q.size() < DEPTH) begin
          m_q.push_back({m_pc, w});
          m_pc = m_pc + 16'd4;
        end
      end
    end
  endtask

  // driver: one clock with the given inputs, then compare against the model
  task automatic cycle(input bit r, input bit rv, input logic [15:0] rpc, input bit rdy);
    logic [47:0] head;
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    model_step(r, rv, rpc, rdy);
    @(posedge clk);
    #1;
    head = (m_q.size() != 0) ? m_q[0] : 48'd0;
    check("imem_addr", 48'(imem_addr), 48'(m_pc));
    check("out_valid", 48'(out_valid), 48'(m_q.size() != 0));
    check("out_pc",    48'(out_pc),    48'(head[47:32]));
    check("out_instr", 48'(out_instr), 48'(head[31:0]));
    check("halted",    48'(halted),    48'(m_halted));
    check("count",     48'(dut.count), 48'(m_q.size()));
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    w[31:26] = 6'($urandom_range(int'(OP_ALU), int'(OP_JUMP)));
    return w;
  endfunction

  initial begin
    bit          r;
    bit          rv;
    bit          rdy;
    logic [15:0] rpc;

    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0000;
    out_ready = 1'b0;
    for (int i = 0; i < 16384; i++) wmem[i] = HALT_WORD;
    for (int i = 0; i < 9; i++) wmem[i] = rand_word();
    wmem[3] = NOP_WORD;
    wmem[16383] = rand_word();

    // reset state
    cycle(1, 0, 16'h0000, 0);
    cycle(1, 0, 16'h0000, 0);
    check("reset out_valid", 48'(out_valid), 48'd0);
    check("reset halted",    48'(halted),    48'd0);
    check("reset imem_addr", 48'(imem_addr), 48'(RESET_PC));
    check("reset out_instr", 48'(out_instr), 48'd0);
    check("reset out_pc",    48'(out_pc),    48'd0);

    // streaming program of 9 words, plus wrap-around on the second instance
    for (int k = 0; k < 9; k++) begin
      cycle(0, 0, 16'h0000, 1);
      check("stream out_pc", 48'(out_pc), 48'(16'(4 * k)));
      check("stream out_instr", 48'(out_instr), 48'(wmem[k]));
      if (k == 0) begin
        check("wrap pc first",    48'(out_pc2),    48'(WRAP_PC));
        check("wrap instr first", 48'(out_instr2), 48'(wmem[16383]));
      end
      if (k == 1) begin
        check("wrap pc second", 48'(out_pc2), 48'd0);
        check("wrap addr", 48'(imem_addr2), 48'd4);
      end
    end
    cycle(0, 0, 16'h0000, 1);
    check("stream halted",    48'(halted),    48'd1);
    check("stream halt addr", 48'(imem_addr), 48'd36);
    check("stream drained",   48'(out_valid), 48'd0);
    cycle(0, 0, 16'h0000, 1);
    check("halt holds addr", 48'(imem_addr), 48'd36);

    // leaving HALT via redirect
    cycle(0, 1, 16'h0004, 1);
    check("unhalt halted", 48'(halted),    48'd0);
    check("unhalt addr",   48'(imem_addr), 48'd4);
    cycle(0, 0, 16'h0000, 1);
    check("unhalt out_pc", 48'(out_pc), 48'd4);

    // backpressure
    cycle(1, 0, 16'h0000, 0);
    for (int k = 0; k < 5; k++) cycle(0, 0, 16'h0000, 0);
    check("bp count",  48'(dut.count), 48'(DEPTH));
    check("bp addr",   48'(imem_addr), 48'd8);
    check("bp out_pc", 48'(out_pc),    48'd0);
    for (int k = 1; k <= 3; k++) begin
      cycle(0, 0, 16'h0000, 1);
      check("bp drain out_pc", 48'(out_pc), 48'(16'(4 * k)));
    end

    // redirect with two entries queued
    cycle(1, 0, 16'h0000, 0);
    cycle(0, 0, 16'h0000, 0);
    cycle(0, 0, 16'h0000, 0);
    check("redir pre count", 48'(dut.count), 48'd2);
    cycle(0, 1, 16'h0012, 1);
    check("redir out_valid", 48'(out_valid), 48'd0);
    check("redir addr",      48'(imem_addr), 48'h0010);
    cycle(0, 0, 16'h0000, 1);
    check("redir out_pc",    48'(out_pc),    48'h0010);

    // reset together with redirect while full
    cycle(0, 0, 16'h0000, 0);
    cycle(0, 0, 16'h0000, 0);
    check("rst pre count", 48'(dut.count), 48'(DEPTH));
    cycle(1, 1, 16'h0020, 1);
    check("rst count",     48'(dut.count), 48'd0);
    check("rst out_valid", 48'(out_valid), 48'd0);
    check("rst addr",      48'(imem_addr), 48'(RESET_PC));

    // randomized phase
    for (int i = 0; i < 32; i++)
      wmem[i] = ($urandom_range(0, 7) == 0) ? HALT_WORD : rand_word();
    wmem[5] = NOP_WORD;
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 99) < 2);
      rv  = ($urandom_range(0, 99) < 6);
      rpc = 16'($urandom_range(0, 130));
      rdy = ($urandom_range(0, 99) < 65);
      cycle(r, rv, rpc, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
